led_pwm_fader: RTL and testbench

Downstream stage of the flowing-light block. Takes the 3-bit LED on/off pattern that block produces and drives the board LEDs with 8-bit PWM. Each channel ramps its brightness linearly toward the commanded state instead of switching hard, so the chase becomes a smooth crossfade. All logic runs in the single system clock domain.

---
 rtl/led_pwm_fader.sv | 96 +++++++++
 tb/tb_led_pwm_fader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_fader.sv
// rtl/led_pwm_fader.sv - three-channel PWM LED fader that ramps each channel linearly toward its on/off target
module led_pwm_fader #(
  parameter int unsigned STEP_MAX = 98038,
  parameter logic        OUT_INV  = 1'b0
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [2:0] led_in,
  output logic [2:0] pwm_out,
  output logic       fading
);

  localparam int STEP_W = (STEP_MAX < 2) ? 1 : $clog2(STEP_MAX + 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_MAX);

  logic [2:0]        led_q;
  logic [7:0]        pwm_cnt;
  logic [STEP_W-1:0] step_cnt;
  logic              step_tick;
  logic [2:0][7:0]   level;
  logic [2:0][7:0]   target;
  logic [2:0]        pwm_raw;

  assign step_tick = (step_cnt == STEP_LAST);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      led_q <= 3'b000;
    end else begin
      led_q <= led_in;
    end
  end

  // 255-clock period so that level 255 never compares false and stays solid on
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pwm_cnt <= 8'd0;
    end else if (pwm_cnt == 8'd254) begin
      pwm_cnt <= 8'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      step_cnt <= '0;
    end else if (step_tick) begin
      step_cnt <= '0;
    end else begin
      step_cnt <= step_cnt + 1'b1;
    end
  end

  always_comb begin
    target = '0;
    for (int i = 0; i < 3; i++) begin
      target[i] = {8{led_q[i]}};
    end
  end

  // Targets are only ever 0 or 255, so stepping toward them can never wrap
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      level <= '0;
    end else if (step_tick) begin
      for (int i = 0; i < 3; i++) begin
        if (level[i] < target[i]) begin
          level[i] <= level[i] + 8'd1;
        end else if (level[i] > target[i]) begin
          level[i] <= level[i] - 8'd1;
        end
      end
    end
  end

  always_comb begin
    pwm_raw = 3'b000;
    fading  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pwm_raw[i] = (pwm_cnt < level[i]);
      if (level[i] != target[i]) begin
        fading = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pwm_out <= {3{OUT_INV}};
    end else begin
      pwm_out <= pwm_raw ^ {3{OUT_INV}};
    end
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// tb/tb_led_pwm_fader.sv - randomized and directed bench for led_pwm_fader against a cycle-index reference model
module tb_led_pwm_fader;

  localparam int SM_A = 3;
  localparam int SM_B = 255;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1;
  logic       rst_b = 1'b1;
  logic [2:0] led_a = 3'b111;
  logic [2:0] led_b = 3'b111;
  logic [2:0] pwm_a;
  logic [2:0] pwm_b;
  logic       fad_a;
  logic       fad_b;

  int checks = 0;
  int errors = 0;

  logic model_on = 1'b0;
  logic duty_done = 1'b0;

  int         m_e = 0;
  int         m_lvl [3] = '{0, 0, 0};
  logic [2:0] m_ledq = 3'b000;
  logic [2:0] m_pwm = 3'b000;

  always #5 clk = ~clk;

  led_pwm_fader #(.STEP_MAX(SM_A), .OUT_INV(1'b0)) dut_a (
    .sys_clk (clk),
    .sys_rst (rst_a),
    .led_in  (led_a),
    .pwm_out (pwm_a),
    .fading  (fad_a)
  );

  led_pwm_fader #(.STEP_MAX(SM_B), .OUT_INV(1'b1)) dut_b (
    .sys_clk (clk),
    .sys_rst (rst_b),
    .led_in  (led_b),
    .pwm_out (pwm_b),
    .fading  (fad_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_fading();
    logic f;
    f = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (m_lvl[i] != (m_ledq[i] ? 255 : 0)) f = 1'b1;
    end
    return f;
  endfunction

  // Reference: edge e (1-based since reset) sees pwm phase (e-1)%255 and
  // a brightness step when (e-1)%(STEP_MAX+1) == STEP_MAX.
  always @(posedge clk or posedge rst_a) begin
    int tgt;
    if (rst_a) begin
      m_e = 0;
      m_ledq = 3'b000;
      m_pwm = 3'b000;
      for (int i = 0; i < 3; i++) m_lvl[i] = 0;
    end else begin
      m_e = m_e + 1;
      for (int i = 0; i < 3; i++) m_pwm[i] = (((m_e - 1) % 255) < m_lvl[i]);
      if (((m_e - 1) % (SM_A + 1)) == SM_A) begin
        for (int i = 0; i < 3; i++) begin
          tgt = m_ledq[i] ? 255 : 0;
          if (m_lvl[i] < tgt) m_lvl[i] = m_lvl[i] + 1;
          else if (m_lvl[i] > tgt) m_lvl[i] = m_lvl[i] - 1;
        end
      end
      m_ledq = led_a;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("model_pwm", pwm_a, m_pwm);
      check("model_fading", fad_a, m_fading());
    end
  end

  initial begin
    int hi;
    int cnt;
    int waited;
    logic [2:0] seq [3];
    seq[0] = 3'b001;
    seq[1] = 3'b010;
    seq[2] = 3'b100;

    repeat (3) @(negedge clk);
    check("rst_pwm", pwm_a, 3'b000);
    check("rst_fading", fad_a, 1'b0);
    led_a = 3'b000;
    rst_a = 1'b0;
    model_on = 1'b1;

    @(negedge clk);
    led_a = 3'b001;
    @(negedge clk);
    check("rise_fading_on", fad_a, 1'b1);
    repeat (1030) @(negedge clk);
    check("rise_fading_off", fad_a, 1'b0);
    hi = 0;
    repeat (300) begin
      @(negedge clk);
      if (pwm_a == 3'b001) hi++;
    end
    check("rise_hold_high", hi, 300);

    led_a = 3'b100;
    waited = 0;
    while (m_lvl[2] != 100 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("rev_reach_100", m_lvl[2] == 100, 1'b1);
    led_a = 3'b000;
    waited = 0;
    @(negedge clk);
    while (fad_a && waited < 1200) begin
      check("rev_fading_held", fad_a, 1'b1);
      @(negedge clk);
      waited++;
    end
    check("rev_fading_off", fad_a, 1'b0);
    check("rev_pwm_off", pwm_a, 3'b000);

    waited = 0;
    while ((m_e % (SM_A + 1)) != SM_A && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    led_a = 3'b010;
    cnt = 0;
    @(negedge clk);
    cnt += fad_a;
    @(negedge clk);
    cnt += fad_a;
    led_a = 3'b000;
    repeat (6) begin
      @(negedge clk);
      cnt += fad_a;
      check("pulse_pwm_off", pwm_a, 3'b000);
    end
    check("pulse_fading_cnt", cnt, 2);

    for (int s = 0; s < 3; s++) begin
      led_a = seq[s];
      repeat (300 * (SM_A + 1)) @(negedge clk);
      check("xfade_settled", fad_a, 1'b0);
      check("xfade_pwm", pwm_a, seq[s]);
    end

    for (int r = 0; r < 40; r++) begin
      led_a = 3'($urandom_range(0, 7));
      repeat ($urandom_range(1, 60)) @(negedge clk);
    end

    led_a = 3'b111;
    repeat (50) @(negedge clk);
    @(posedge clk);
    #3;
    rst_a = 1'b1;
    #1;
    check("async_rst_pwm", pwm_a, 3'b000);
    check("async_rst_fading", fad_a, 1'b0);
    @(negedge clk);
    rst_a = 1'b0;
    repeat (600) @(negedge clk);

    model_on = 1'b0;
    waited = 0;
    while (!duty_done && waited < 90000) begin
      @(negedge clk);
      waited++;
    end
    check("duty_done", duty_done, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Active-low instance: a level N shows exactly N low clocks in any
  // 255-clock window lying between two brightness steps.
  initial begin
    int eb;
    int lows;
    int others;
    int lv [3];
    lv[0] = 1;
    lv[1] = 128;
    lv[2] = 254;

    repeat (2) @(negedge clk);
    check("rst_pwm_inv", pwm_b, 3'b111);
    check("rst_fading_b", fad_b, 1'b0);
    led_b = 3'b010;
    rst_b = 1'b0;
    eb = 0;
    for (int k = 0; k < 3; k++) begin
      while (eb < (SM_B + 1) * lv[k] + 1) begin
        @(negedge clk);
        eb++;
      end
      lows = 0;
      others = 0;
      for (int j = 0; j < 255; j++) begin
        if (pwm_b[1] == 1'b0) lows++;
        if (pwm_b[0] == 1'b1 && pwm_b[2] == 1'b1) others++;
        if (j < 254) begin
          @(negedge clk);
          eb++;
        end
      end
      check("duty_lows", lows, lv[k]);
      check("duty_idle_ch", others, 255);
      check("duty_fading", fad_b, 1'b1);
    end
    duty_done = 1'b1;
  end

endmodule
